// File: rtl/s3_csee_par.sv
// Stage-3 Chien search / Forney evaluator for a t=2 RS decoder over GF(2^8), poly 0x11D.
// Evaluates P consecutive codeword positions per beat and streams error magnitudes
// over a valid/ready handshake, then reports root count and decode-fail verdict.
module s3_csee_par #(
    parameter int P         = 8,
    parameter int N         = 198,
    parameter int START_EXP = 58
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           rs_ena,
    input  logic           csee_ena,
    output logic           csee_rdy,
    input  logic [7:0]     rs_lambda0,
    input  logic [7:0]     rs_lambda1,
    input  logic [7:0]     rs_lambda2,
    input  logic [7:0]     rs_omega0,
    input  logic [7:0]     rs_omega1,
    output logic           err_vld,
    input  logic           err_rdy,
    output logic [8*P-1:0] err_data,
    output logic [7:0]     err_beat,
    output logic           err_last,
    output logic           csee_done,
    output logic [7:0]     err_count,
    output logic           rs_decode_fail
);

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ t;
            t = gf_xtime(t);
        end
        return r;
    endfunction

    // alpha^e with the exponent reduced modulo 255; only ever called with constants
    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        int         k;
        r = 8'h01;
        k = e % 255;
        for (int i = 0; i < 254; i++) begin
            if (i < k) r = gf_xtime(r);
        end
        return r;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount(input logic [P-1:0] f);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < P; i++) c = c + 5'(f[i]);
        return c;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {4'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    localparam int         NB   = (N + P - 1) / P;
    localparam logic [7:0] A_S  = gf_pow(START_EXP);
    localparam logic [7:0] A_2S = gf_pow(2 * START_EXP);
    localparam logic [7:0] A_P  = gf_pow(P);
    localparam logic [7:0] A_2P = gf_pow(2 * P);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]     r_l0, r_l1, r_l2, r_o0;
    logic [7:0]     r_L1, r_L2, r_O1;
    logic [7:0]     r_beat, r_count;
    logic [8*P-1:0] r_data;
    logic [P-1:0]   r_flags;
    logic           r_bad_beat, r_any_bad, r_fail;

    logic           w_start, w_accept, w_last_beat, w_fail;
    logic [7:0]     w_deg;
    logic [7:0]     w_src_l0, w_src_o0, w_src_L1, w_src_L2, w_src_O1, w_src_beat;
    logic [8*P-1:0] w_data;
    logic [P-1:0]   w_flag, w_bad_l;

    assign w_last_beat = (r_beat == 8'(NB - 1));
    assign w_start     = (r_state == S_IDLE) && csee_ena && rs_ena;
    assign w_accept    = (r_state == S_RUN) && err_rdy;
    assign w_deg       = (r_l2 != 8'h00) ? 8'd2 : ((r_l1 != 8'h00) ? 8'd1 : 8'd0);
    assign w_fail      = (r_count == 8'd0) || (r_count > 8'd2) || (r_count != w_deg) || r_any_bad;

    // Running terms for the beat about to be registered: fresh from the inputs in IDLE, stepped otherwise
    always_comb begin
        w_src_l0   = r_l0;
        w_src_o0   = r_o0;
        w_src_L1   = gf_mul(r_L1, A_P);
        w_src_L2   = gf_mul(r_L2, A_2P);
        w_src_O1   = gf_mul(r_O1, A_P);
        w_src_beat = r_beat + 8'd1;
        if (r_state == S_IDLE) begin
            w_src_l0   = rs_lambda0;
            w_src_o0   = rs_omega0;
            w_src_L1   = gf_mul(rs_lambda1, A_S);
            w_src_L2   = gf_mul(rs_lambda2, A_2S);
            w_src_O1   = gf_mul(rs_omega1, A_S);
            w_src_beat = 8'd0;
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_lane
        localparam logic [7:0] AJ  = gf_pow(j);
        localparam logic [7:0] A2J = gf_pow(2 * j);
        logic [7:0] w_l1j, w_l2j, w_o1j;
        logic       w_in_range;
        assign w_l1j      = gf_mul(w_src_L1, AJ);
        assign w_l2j      = gf_mul(w_src_L2, A2J);
        assign w_o1j      = gf_mul(w_src_O1, AJ);
        assign w_in_range = (int'(w_src_beat) * P + j) < N;
        assign w_flag[j]  = w_in_range && ((w_src_l0 ^ w_l1j ^ w_l2j) == 8'h00);
        assign w_bad_l[j] = w_flag[j] && (w_l1j == 8'h00);
        assign w_data[8*P-1-8*j -: 8] = w_flag[j] ? gf_mul(w_src_o0 ^ w_o1j, gf_inv(w_l1j)) : 8'h00;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state; rs_ena low forces IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (!rs_ena) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (csee_ena) w_state_nxt = S_RUN;
                S_RUN:   if (err_rdy && w_last_beat) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: load on start, advance on accepted beat, latch verdict in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_l0 <= 8'h00; r_l1 <= 8'h00; r_l2 <= 8'h00; r_o0 <= 8'h00;
            r_L1 <= 8'h00; r_L2 <= 8'h00; r_O1 <= 8'h00;
            r_beat     <= 8'd0;
            r_count    <= 8'd0;
            r_data     <= '0;
            r_flags    <= '0;
            r_bad_beat <= 1'b0;
            r_any_bad  <= 1'b0;
            r_fail     <= 1'b0;
        end else if (!rs_ena) begin
            r_fail <= 1'b0;
        end else if (w_start) begin
            r_l0 <= rs_lambda0; r_l1 <= rs_lambda1; r_l2 <= rs_lambda2; r_o0 <= rs_omega0;
            r_L1 <= w_src_L1; r_L2 <= w_src_L2; r_O1 <= w_src_O1;
            r_beat     <= w_src_beat;
            r_data     <= w_data;
            r_flags    <= w_flag;
            r_bad_beat <= |w_bad_l;
            r_count    <= 8'd0;
            r_any_bad  <= 1'b0;
            r_fail     <= 1'b0;
        end else if (w_accept) begin
            r_count   <= sat_add(r_count, popcount(r_flags));
            r_any_bad <= r_any_bad | r_bad_beat;
            if (!w_last_beat) begin
                r_L1 <= w_src_L1; r_L2 <= w_src_L2; r_O1 <= w_src_O1;
                r_beat     <= w_src_beat;
                r_data     <= w_data;
                r_flags    <= w_flag;
                r_bad_beat <= |w_bad_l;
            end
        end else if (r_state == S_DONE) begin
            r_fail <= w_fail;
        end
    end

    assign csee_rdy       = (r_state == S_IDLE);
    assign err_vld        = (r_state == S_RUN);
    assign csee_done      = (r_state == S_DONE);
    assign err_last       = err_vld && w_last_beat;
    assign err_data       = r_data;
    assign err_beat       = r_beat;
    assign err_count      = r_count;
    assign rs_decode_fail = csee_done ? w_fail : r_fail;

endmodule

// File: tb/tb_s3_csee_par.sv
module tb_s3_csee_par;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Instance A: P=8, N=255, START_EXP=0
    logic        a_rs_ena, a_csee_ena, a_csee_rdy, a_err_vld, a_err_rdy, a_err_last, a_csee_done, a_fail;
    logic [7:0]  a_l0, a_l1, a_l2, a_o0, a_o1, a_err_beat, a_err_count;
    logic [63:0] a_err_data;
    // Instance B: default parameters
    logic        b_rs_ena, b_csee_ena, b_csee_rdy, b_err_vld, b_err_rdy, b_err_last, b_csee_done, b_fail;
    logic [7:0]  b_l0, b_l1, b_l2, b_o0, b_o1, b_err_beat, b_err_count;
    logic [63:0] b_err_data;

    s3_csee_par #(.P(8), .N(255), .START_EXP(0)) u_a (
        .clk(clk), .rstn(rstn), .rs_ena(a_rs_ena), .csee_ena(a_csee_ena), .csee_rdy(a_csee_rdy),
        .rs_lambda0(a_l0), .rs_lambda1(a_l1), .rs_lambda2(a_l2), .rs_omega0(a_o0), .rs_omega1(a_o1),
        .err_vld(a_err_vld), .err_rdy(a_err_rdy), .err_data(a_err_data), .err_beat(a_err_beat),
        .err_last(a_err_last), .csee_done(a_csee_done), .err_count(a_err_count), .rs_decode_fail(a_fail));

    s3_csee_par u_b (
        .clk(clk), .rstn(rstn), .rs_ena(b_rs_ena), .csee_ena(b_csee_ena), .csee_rdy(b_csee_rdy),
        .rs_lambda0(b_l0), .rs_lambda1(b_l1), .rs_lambda2(b_l2), .rs_omega0(b_o0), .rs_omega1(b_o1),
        .err_vld(b_err_vld), .err_rdy(b_err_rdy), .err_data(b_err_data), .err_beat(b_err_beat),
        .err_last(b_err_last), .csee_done(b_csee_done), .err_count(b_err_count), .rs_decode_fail(b_fail));

    typedef struct { logic [63:0] d; logic [7:0] beat; logic last; } beat_t;
    typedef struct { logic [7:0] cnt; logic fail; } res_t;
    beat_t qa[$], qb[$];
    res_t  ra[$], rb[$];
    res_t  ma_r, mb_r;
    int    n_chk = 0, n_fail = 0;
    int    a_beats = 0, b_beats = 0, a_dones = 0, b_dones = 0;

    logic [7:0] gexp [0:254];
    int         glog [0:255];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [7:0] tdiv(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00) return 8'h00;
        return gexp[(glog[a] - glog[b] + 255) % 255];
    endfunction

    // Reference model: evaluate Lambda directly at every position and queue the expected stream
    task automatic push_run(input bit to_b, input int p, input int n, input int s,
                            input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                            input logic [7:0] o0, input logic [7:0] o1);
        int nb, cnt, idx, deg;
        bit bad;
        logic [7:0] x, lam, d;
        beat_t bt;
        res_t rr;
        nb = (n + p - 1) / p; cnt = 0; bad = 0;
        for (int b = 0; b < nb; b++) begin
            bt.d = '0;
            for (int j = 0; j < p; j++) begin
                idx = b * p + j;
                if (idx < n) begin
                    x = gexp[(s + idx) % 255];
                    lam = l0 ^ tmul(l1, x) ^ tmul(l2, tmul(x, x));
                    if (lam == 8'h00) begin
                        cnt++;
                        d = tmul(l1, x);
                        if (d == 8'h00) bad = 1;
                        else bt.d[63-8*j -: 8] = tdiv(o0 ^ tmul(o1, x), d);
                    end
                end
            end
            bt.beat = 8'(b);
            bt.last = (b == nb - 1);
            if (to_b) qb.push_back(bt); else qa.push_back(bt);
        end
        deg = (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
        rr.cnt  = (cnt > 255) ? 8'hFF : 8'(cnt);
        rr.fail = (cnt == 0) || (cnt > 2) || (cnt != deg) || bad;
        if (to_b) rb.push_back(rr); else ra.push_back(rr);
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (rstn && a_err_vld) begin
            if (qa.size() == 0) chk("A_extra_beat", 64'd1, 64'd0);
            else begin
                chk("A_data", a_err_data, qa[0].d);
                chk("A_beat", {56'd0, a_err_beat}, {56'd0, qa[0].beat});
                chk("A_last", {63'd0, a_err_last}, {63'd0, qa[0].last});
                if (a_err_rdy) begin qa.delete(0); a_beats++; end
            end
        end
        if (rstn && a_csee_done) begin
            a_dones++;
            if (ra.size() == 0) chk("A_extra_done", 64'd1, 64'd0);
            else begin
                ma_r = ra.pop_front();
                chk("A_count", {56'd0, a_err_count}, {56'd0, ma_r.cnt});
                chk("A_fail", {63'd0, a_fail}, {63'd0, ma_r.fail});
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rstn && b_err_vld) begin
            if (qb.size() == 0) chk("B_extra_beat", 64'd1, 64'd0);
            else begin
                chk("B_data", b_err_data, qb[0].d);
                chk("B_beat", {56'd0, b_err_beat}, {56'd0, qb[0].beat});
                chk("B_last", {63'd0, b_err_last}, {63'd0, qb[0].last});
                if (b_err_rdy) begin qb.delete(0); b_beats++; end
            end
        end
        if (rstn && b_csee_done) begin
            b_dones++;
            if (rb.size() == 0) chk("B_extra_done", 64'd1, 64'd0);
            else begin
                mb_r = rb.pop_front();
                chk("B_count", {56'd0, b_err_count}, {56'd0, mb_r.cnt});
                chk("B_fail", {63'd0, b_fail}, {63'd0, mb_r.fail});
            end
        end
    end

    task automatic start_a(input logic [7:0] l0, l1, l2, o0, o1);
        push_run(0, 8, 255, 0, l0, l1, l2, o0, o1);
        a_l0 = l0; a_l1 = l1; a_l2 = l2; a_o0 = o0; a_o1 = o1;
        a_beats = 0; a_dones = 0;
        a_csee_ena = 1'b1;
        @(posedge clk); #1;
        a_csee_ena = 1'b0;
    endtask

    task automatic wait_done_a;
        for (int k = 0; k < 1000 && !a_csee_done; k++) begin @(posedge clk); #1; end
        chk("A_done_seen", {63'd0, a_csee_done}, 64'd1);
        chk("A_rdy_in_done", {63'd0, a_csee_rdy}, 64'd0);
    endtask

    task automatic wait_beat_a(input logic [7:0] bt);
        for (int k = 0; k < 1000 && !(a_err_vld && a_err_beat == bt); k++) begin @(posedge clk); #1; end
        chk("A_beat_reached", {63'd0, (a_err_vld && a_err_beat == bt)}, 64'd1);
    endtask

    task automatic after_a(input logic [7:0] cnt, input logic fl, input int beats);
        @(posedge clk); #1;
        chk("A_count_hold", {56'd0, a_err_count}, {56'd0, cnt});
        chk("A_fail_hold", {63'd0, a_fail}, {63'd0, fl});
        chk("A_beats_total", 64'(a_beats), 64'(beats));
        chk("A_done_pulses", 64'(a_dones), 64'd1);
    endtask

    task automatic run_b(input logic [7:0] l0, l1, l2, o0, o1, input bit hold_ena,
                         input logic [7:0] cnt, input logic fl);
        push_run(1, 8, 198, 58, l0, l1, l2, o0, o1);
        b_l0 = l0; b_l1 = l1; b_l2 = l2; b_o0 = o0; b_o1 = o1;
        b_beats = 0; b_dones = 0;
        b_csee_ena = 1'b1;
        @(posedge clk); #1;
        if (!hold_ena) b_csee_ena = 1'b0;
        for (int k = 0; k < 1000 && !b_csee_done; k++) begin @(posedge clk); #1; end
        chk("B_done_seen", {63'd0, b_csee_done}, 64'd1);
        chk("B_rdy_in_done", {63'd0, b_csee_rdy}, 64'd0);
        b_csee_ena = 1'b0;
        @(posedge clk); #1;
        chk("B_idle_after", {62'd0, b_csee_rdy, b_err_vld}, 64'b10);
        chk("B_count_hold", {56'd0, b_err_count}, {56'd0, cnt});
        chk("B_fail_hold", {63'd0, b_fail}, {63'd0, fl});
        chk("B_beats_total", 64'(b_beats), 64'd25);
        chk("B_done_pulses", 64'(b_dones), 64'd1);
    endtask

    initial begin
        logic [8:0] v;
        v = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v[7:0];
            glog[v[7:0]] = i;
            v = {v[7:0], 1'b0};
            if (v[8]) v = v ^ 9'h11D;
        end
        glog[0] = 0;

        rstn = 1'b0;
        a_rs_ena = 1'b1; a_csee_ena = 1'b0; a_err_rdy = 1'b1;
        a_l0 = 0; a_l1 = 0; a_l2 = 0; a_o0 = 0; a_o1 = 0;
        b_rs_ena = 1'b1; b_csee_ena = 1'b0; b_err_rdy = 1'b1;
        b_l0 = 0; b_l1 = 0; b_l2 = 0; b_o0 = 0; b_o1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("RST_rdy", {63'd0, a_csee_rdy}, 64'd1);
        chk("RST_ctrl", {60'd0, a_err_vld, a_err_last, a_csee_done, a_fail}, 64'd0);
        chk("RST_data", a_err_data, 64'd0);
        chk("RST_beat_count", {48'd0, a_err_beat, a_err_count}, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single root alpha^250 -> beat 31 lane 2 = 5A
        start_a(8'h01, 8'h20, 8'h00, 8'h5A, 8'h00);
        wait_done_a();
        after_a(8'd1, 1'b0, 32);

        // No roots -> decode fail
        start_a(8'h01, 8'h00, 8'h00, 8'h5A, 8'h00);
        wait_done_a();
        after_a(8'd0, 1'b1, 32);

        // Two roots alpha^10, alpha^100
        start_a(8'h01, gexp[245] ^ gexp[155], gexp[145], 8'h33, 8'h07);
        wait_done_a();
        after_a(8'd2, 1'b0, 32);

        // Same stream with a 3-cycle stall on beat 4
        start_a(8'h01, gexp[245] ^ gexp[155], gexp[145], 8'h33, 8'h07);
        wait_beat_a(8'd4);
        a_err_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_err_rdy = 1'b1;
        wait_done_a();
        after_a(8'd2, 1'b0, 32);

        // Abort during beat 10, then a clean restart
        start_a(8'h01, 8'h20, 8'h00, 8'h5A, 8'h00);
        wait_beat_a(8'd10);
        a_rs_ena = 1'b0;
        @(posedge clk); #1;
        chk("ABORT_vld", {63'd0, a_err_vld}, 64'd0);
        chk("ABORT_rdy", {63'd0, a_csee_rdy}, 64'd1);
        chk("ABORT_fail", {63'd0, a_fail}, 64'd0);
        qa.delete();
        ra.delete();
        a_rs_ena = 1'b1;
        start_a(8'h01, 8'h20, 8'h00, 8'h5A, 8'h00);
        wait_done_a();
        after_a(8'd1, 1'b0, 32);

        // Default parameters: csee_ena held through RUN and DONE, root at beat 24 lane 0
        run_b(8'h01, 8'h20, 8'h00, 8'h5A, 8'h00, 1'b1, 8'd1, 1'b0);
        // Second root alpha^1 falls in masked lane 6 of beat 24
        run_b(8'h01, gexp[5] ^ gexp[254], gexp[4], 8'h11, 8'h22, 1'b0, 8'd1, 1'b1);

        chk("A_queue_empty", 64'(qa.size() + ra.size()), 64'd0);
        chk("B_queue_empty", 64'(qb.size() + rb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
